dcache_mem_responder: RTL and testbench

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

---
 rtl/dcache_mem_responder_if.sv | 27 ++
 rtl/dcache_mem_responder.sv | 121 ++++++++++++
 tb/tb_dcache_mem_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_responder_if.sv
// Request/response bus between a data cache and its backing-memory responder.
interface dcache_mem_responder_if #(
    parameter int PLEN       = 34,
    parameter int LINE_WIDTH = 128
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_we_i;
    logic [PLEN-1:0]         req_addr_i;
    logic [2:0]              req_size_i;
    logic [LINE_WIDTH-1:0]   req_wdata_i;
    logic [LINE_WIDTH/8-1:0] req_be_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [LINE_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dcache_mem_responder.sv
// Single-outstanding backing memory for the data cache: fixed-latency line reads,
// byte-enabled line or sub-bank writes, error response for illegal requests.
module dcache_mem_responder #(
    parameter int PLEN       = 34,
    parameter int LINE_WIDTH = 128,
    parameter int NUM_LINES  = 512,
    parameter int LATENCY    = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    dcache_mem_responder_if.slave bus
);

    localparam int NB   = LINE_WIDTH / 8;
    localparam int HB   = NB / 2;
    localparam int IW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int IDXW = PLEN - 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic                    we_q;
    logic [PLEN-1:0]         addr_q;
    logic [2:0]              size_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           be_q;
    logic                    ready_q, valid_q, err_q;
    logic [LINE_WIDTH-1:0]   rdata_q;
    logic                    hs, access, err, size_bad, misalign, range_bad;
    logic [NB-1:0]           be_eff;
    logic [IW-1:0]           idx;

    // Backing store is deliberately outside reset; it starts zeroed.
    logic [LINE_WIDTH-1:0]   mem [NUM_LINES] = '{default: '0};

    assign hs              = bus.req_valid_i & ready_q;
    assign bus.req_ready_o = ready_q;
    assign bus.rsp_valid_o = valid_q;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

    always_comb begin
        size_bad = 1'b0;
        misalign = 1'b0;
        case (size_q)
            3'b000:  ;
            3'b001:  misalign = addr_q[0];
            3'b010:  misalign = |addr_q[1:0];
            3'b011:  misalign = |addr_q[2:0];
            3'b111:  ;
            default: size_bad = 1'b1;
        endcase
        range_bad = addr_q[PLEN-1:4] >= IDXW'(NUM_LINES);
        err       = size_bad | misalign | range_bad;
        idx       = addr_q[4 +: IW];
        // Sub-line writes only touch the bank selected by addr[3].
        for (int b = 0; b < NB; b++)
            be_eff[b] = be_q[b] & ((size_q == 3'b111) | ((b >= HB) == addr_q[3]));
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        access  = 1'b0;
        case (state)
            IDLE: if (hs) begin
                state_n = WAIT;
                cnt_n   = 4'(LATENCY - 1);
            end
            WAIT: if (cnt == 4'd0) begin
                state_n = RESP;
                access  = 1'b1;
            end else begin
                cnt_n = cnt - 4'd1;
            end
            RESP: if (bus.rsp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 3'b000;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ready_q <= (state_n == IDLE);
            valid_q <= (state_n == RESP);
            if (hs) begin
                we_q    <= bus.req_we_i;
                addr_q  <= bus.req_addr_i;
                size_q  <= bus.req_size_i;
                wdata_q <= bus.req_wdata_i;
                be_q    <= bus.req_be_i;
            end
            if (access) begin
                err_q   <= err;
                rdata_q <= (!we_q && !err) ? mem[idx] : '0;
            end
        end
    end

    // A reset on the access edge aborts the write before it lands.
    always_ff @(posedge clk_i) begin
        if (!rst_i && access && we_q && !err)
            for (int b = 0; b < NB; b++)
                if (be_eff[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Randomized bench for dcache_mem_responder against a byte-addressed memory model.
module tb_dcache_mem_responder;

    localparam int PLEN = 34;
    localparam int LW   = 128;
    localparam int NL   = 512;
    localparam int LAT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_mem_responder_if #(.PLEN(PLEN), .LINE_WIDTH(LW)) bus ();

    dcache_mem_responder #(.PLEN(PLEN), .LINE_WIDTH(LW), .NUM_LINES(NL), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] mb [NL*16];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory; sizes as byte counts, alignment by modulo.
    task automatic model(input bit we, input logic [PLEN-1:0] a, input logic [2:0] sz,
                         input logic [127:0] wd, input logic [15:0] be,
                         output bit err, output logic [127:0] rd);
        int  nb;
        longint line;
        case (sz)
            3'd0: nb = 1;
            3'd1: nb = 2;
            3'd2: nb = 4;
            3'd3: nb = 8;
            3'd7: nb = 16;
            default: nb = 0;
        endcase
        line = longint'(a >> 4);
        err  = (nb == 0) || (line >= NL) || (sz != 3'd7 && (int'(a[3:0]) % nb) != 0);
        rd   = '0;
        if (!err) begin
            for (int b = 0; b < 16; b++) begin
                if (!we)
                    rd[8*b +: 8] = mb[int'(line)*16 + b];
                else if (be[b] && (sz == 3'd7 || (b / 8) == int'(a[3])))
                    mb[int'(line)*16 + b] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic xact(input bit we, input logic [PLEN-1:0] a, input logic [2:0] sz,
                        input logic [127:0] wd, input logic [15:0] be, input int hold,
                        output logic [127:0] rd_obs, output logic err_obs);
        bit e_err;
        logic [127:0] e_rd;
        int n;
        model(we, a, sz, wd, be, e_err, e_rd);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = a;
        bus.req_size_i  = sz;
        bus.req_wdata_i = wd;
        bus.req_be_i    = be;
        n = 0;
        while (bus.req_ready_o !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        chk("ready_wait", 128'(n < 20), 128'(1));
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'($urandom);
        bus.req_addr_i  = {2'($urandom), $urandom};
        bus.req_size_i  = 3'($urandom);
        bus.req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
        bus.req_be_i    = 16'($urandom);
        bus.rsp_ready_i = 1'($urandom);
        chk("ready_busy", 128'(bus.req_ready_o), 128'(0));
        n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        chk("latency", 128'(n), 128'(LAT));
        rd_obs  = bus.rsp_rdata_o;
        err_obs = bus.rsp_err_o;
        chk("err", 128'(err_obs), 128'(e_err));
        chk("rdata", rd_obs, e_rd);
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_vld", 128'(bus.rsp_valid_o), 128'(1));
            chk("hold_rdata", bus.rsp_rdata_o, e_rd);
            chk("hold_err", 128'(bus.rsp_err_o), 128'(e_err));
            chk("hold_rdy", 128'(bus.req_ready_o), 128'(0));
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        chk("done_vld", 128'(bus.rsp_valid_o), 128'(0));
        chk("idle_rdy", 128'(bus.req_ready_o), 128'(1));
    endtask

    initial begin
        logic [127:0] rd;
        logic         er;
        logic [127:0] pat;
        int           nv;
        for (int i = 0; i < NL*16; i++) mb[i] = 8'h00;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_size_i  = 3'b000;
        bus.req_wdata_i = '0;
        bus.req_be_i    = '0;
        bus.rsp_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 128'(bus.rsp_valid_o), 128'(0));
        chk("rst_rdata", bus.rsp_rdata_o, 128'(0));
        chk("rst_err", 128'(bus.rsp_err_o), 128'(0));
        chk("rst_rdy", 128'(bus.req_ready_o), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdy", 128'(bus.req_ready_o), 128'(1));

        // Word write into a zeroed line touches bytes 8-11 only.
        xact(1'b1, 34'h108, 3'b010, {32'h0, 32'hDEADBEEF, 64'h0}, 16'h0F00, 0, rd, er);
        xact(1'b0, 34'h100, 3'b011, '0, '0, 0, rd, er);
        chk("word_line", rd, 128'h0000_0000_DEADBEEF_0000_0000_0000_0000);

        pat = 128'h0123456789ABCDEF_0123456789ABCDEF;
        xact(1'b1, 34'h100, 3'b111, pat, 16'hFFFF, 0, rd, er);
        chk("line_wr_err", 128'(er), 128'(0));
        xact(1'b0, 34'h100, 3'b111, '0, '0, 0, rd, er);
        chk("line_rd", rd, pat);

        xact(1'b0, 34'h100, 3'b000, '0, '0, 3, rd, er);

        xact(1'b1, 34'(NL*16), 3'b111, '1, 16'hFFFF, 0, rd, er);
        chk("range_err", 128'(er), 128'(1));
        xact(1'b1, 34'h101, 3'b001, '1, 16'hFFFF, 1, rd, er);
        chk("align_err", 128'(er), 128'(1));
        chk("align_rdata", rd, 128'(0));
        xact(1'b0, 34'h100, 3'b101, '0, '0, 0, rd, er);
        xact(1'b0, 34'h100, 3'b111, '0, '0, 0, rd, er);
        chk("unchanged", rd, pat);

        // Reset in WAIT aborts a pending write.
        xact(1'b1, 34'h200, 3'b111, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_1111, 16'hFFFF, 0, rd, er);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 34'h200;
        bus.req_size_i  = 3'b111;
        bus.req_wdata_i = '1;
        bus.req_be_i    = 16'hFFFF;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_vld", 128'(bus.rsp_valid_o), 128'(0));
        chk("abort_rdata", bus.rsp_rdata_o, 128'(0));
        chk("abort_err", 128'(bus.rsp_err_o), 128'(0));
        chk("abort_rdy", 128'(bus.req_ready_o), 128'(0));
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o === 1'b1) nv++;
        end
        chk("abort_no_rsp", 128'(nv), 128'(0));
        chk("abort_idle", 128'(bus.req_ready_o), 128'(1));
        xact(1'b0, 34'h200, 3'b111, '0, '0, 0, rd, er);
        chk("abort_keep", rd, 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_1111);

        for (int it = 0; it < 80; it++) begin
            int          line, low, r;
            logic [2:0]  sz;
            line = ($urandom_range(0, 9) == 0) ? NL + int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    sz = 3'b111;
                2:       sz = 3'b000;
                3:       sz = 3'b001;
                4, 5:    sz = 3'b010;
                6, 7:    sz = 3'b011;
                default: sz = 3'(4 + $urandom_range(0, 2));
            endcase
            low = int'($urandom_range(0, 15));
            if (sz < 3'd4 && $urandom_range(0, 3) != 0) low = low & ~((1 << sz) - 1);
            xact(1'($urandom), 34'(line * 16 + low), sz,
                 {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                 int'($urandom_range(0, 3)), rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
